mmio_fabric: RTL and testbench
==============================

// Module: mmio_fabric
// PURPOSE
//   Parametrised memory-mapped I/O fabric between the CPU data port and N peripheral slaves.
//   - Decodes the top address nibble through a programmable map; each nibble selects a slave index or is unmapped.
//   - Registers each request and runs a valid/ready handshake to the selected slave.
//   - Converts unmapped accesses and slave timeouts into a bus error.
//   - Logs the first faulting access until software clears it.
// PARAMETERS
//   N_SLAVES   9                          number of slave ports (1..15)
//   MAP        64'hFFFF_8876_5432_1100    nibble k = slave index for addr[31:28]==k; 4'hF = unmapped
//   TIMEOUT    255                        ACCESS cycles allowed before error (1..2**TO_W-1)
//   TO_W       8                          timeout counter width
// PORTS
//   clk          in   1          system clock
//   rst          in   1          asynchronous active-high reset
//   m_valid      in   1          master request valid; held until m_ready
//   m_addr       in   32         master byte address
//   m_wdata      in   32         master write data
//   m_wstrb      in   4          byte write enables; 4'b0000 = read
//   m_ready      out  1          one-cycle completion strobe
//   m_rdata      out  32         read data; valid only while m_ready=1
//   m_err        out  1          error flag; valid only while m_ready=1
//   s_valid      out  N_SLAVES   one-hot request to the selected slave
//   s_addr       out  32         latched address, shared by all slaves
//   s_wdata      out  32         latched write data, shared by all slaves
//   s_wstrb      out  4          latched strobes; all zero when no s_valid bit is set
//   s_ready      in   N_SLAVES   per-slave completion
//   s_rdata      in   32*N       slave i read data on bits [32*i+31:32*i]
//   fault_valid  out  1          sticky: a fault has been logged
//   fault_addr   out  32         address of the logged fault
//   fault_write  out  1          1 if the logged fault was a write
//   fault_timeout out 1          1 = timeout, 0 = unmapped
//   fault_clear  in   1          clears fault_valid
// BEHAVIOUR
//   Clock and reset: one clock; reset is asynchronous and active-high.
//   Reset: state IDLE; every output 0; timeout counter 0; fault log cleared.
//   Reset asserted mid-transfer: the transfer is aborted and no m_ready is issued.
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE, m_valid=1:
//     - latch addr, wdata, wstrb; sel = MAP[4*addr[31:28] +: 4]
//     - if sel==4'hF or sel>=N_SLAVES: go to RESP with err=1, rdata=0, log fault (timeout=0)
//     - otherwise go to ACCESS with counter=0
//   ACCESS:
//     - s_valid[sel]=1; s_addr, s_wdata and s_wstrb are driven from the latches and stay stable
//     - s_ready[sel]=1: capture s_rdata slice into m_rdata, err=0, go to RESP
//     - else if counter==TIMEOUT-1: err=1, rdata=0, log fault (timeout=1), go to RESP
//     - else counter+1
//     - s_ready bits of unselected slaves are ignored
//   RESP:
//     - m_ready=1 for exactly one cycle, then IDLE
//     - m_valid is ignored during RESP
//     - the master must drop m_valid or present a new request on the next cycle
//   Latency: m_valid sampled at edge 0; zero-wait slave gives s_valid in cycle 1, m_ready in cycle 2.
//     - each slave wait cycle adds one cycle
//     - unmapped access gives m_ready in cycle 1
//     - throughput: at most one transfer every 3 cycles
//   Fault log:
//     - captures only when fault_valid==0; later faults do not overwrite
//     - fault_clear and a new fault in the same cycle: the new fault is captured and fault_valid stays 1
//   m_rdata and m_err are registered; both are 0 outside RESP.
// TESTING
//   1. Read 0x1000_0004; slave 1 s_ready in its first ACCESS cycle, s_rdata=0xDEADBEEF
//      -> s_valid=9'b000000010 for 1 cycle; m_ready at cycle 2, m_rdata=0xDEADBEEF, m_err=0.
//   2. Write 0x0000_0010, wdata 0x12345678, wstrb 4'b0011; slave 0 waits 3 cycles
//      -> s_wstrb=4'b0011 stable for 4 cycles; m_ready at cycle 5, m_err=0.
//   3. Read 0xC000_0000 with MAP nibble 12 set to F
//      -> no s_valid; m_ready at cycle 1, m_err=1, m_rdata=0;
//         fault_valid=1, fault_addr=0xC000_0000, fault_timeout=0.
//   4. TIMEOUT=4; slave 2 never ready
//      -> s_valid[2] high exactly 4 cycles, then m_ready with m_err=1 and fault_timeout=1;
//         a second fault leaves fault_addr unchanged.
//   5. Pulse fault_clear in the same cycle a new unmapped access is logged
//      -> fault_valid stays 1; fault_addr = new address.
//   6. Assert rst during ACCESS
//      -> s_valid=0 and all outputs 0 immediately; no m_ready; next request after release completes normally.

Source files
------------

// File: rtl/mmio_fabric.sv
// mmio_fabric
//   Memory-mapped I/O fabric between a CPU data port and N_SLAVES peripherals.
//   The top address nibble is decoded through MAP into a slave index; the
//   request is latched and presented to that slave with a valid/ready
//   handshake. Unmapped accesses and slave timeouts complete with m_err=1,
//   and the first such fault is held in a sticky log until software clears it.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     m_valid/m_addr/m_wdata/m_wstrb   master request (m_wstrb==0 is a read)
//     m_ready/m_rdata/m_err     one-cycle completion with registered data/error
//     s_valid                   one-hot request to the selected slave
//     s_addr/s_wdata/s_wstrb    latched request fields shared by all slaves
//     s_ready/s_rdata           per-slave completion and read data slices
//     fault_*                   sticky first-fault log, fault_clear to re-arm
//
//   state  | meaning
//   IDLE   | waiting for m_valid; decodes and latches the request
//   ACCESS | s_valid asserted to the selected slave, timeout counter running
//   RESP   | m_ready pulse with registered m_rdata/m_err

module mmio_fabric #(
    parameter int          N_SLAVES = 9,
    parameter logic [63:0] MAP      = 64'hFFFF_8876_5432_1100,
    parameter int          TIMEOUT  = 255,
    parameter int          TO_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wstrb,
    output logic                     m_ready,
    output logic [31:0]              m_rdata,
    output logic                     m_err,
    output logic [N_SLAVES-1:0]      s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [N_SLAVES-1:0]      s_ready,
    input  logic [32*N_SLAVES-1:0]   s_rdata,
    output logic                     fault_valid,
    output logic [31:0]              fault_addr,
    output logic                     fault_write,
    output logic                     fault_timeout,
    input  logic                     fault_clear
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [3:0]        sel_q, sel_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              fault_valid_q, fault_valid_d;
    logic [31:0]       fault_addr_q, fault_addr_d;
    logic              fault_write_q, fault_write_d;
    logic              fault_timeout_q, fault_timeout_d;

    logic [N_SLAVES-1:0] sel_oh;
    logic [31:0]         slave_rdata;
    logic [3:0]          map_sel;
    logic                unmapped;
    logic                fault_event;
    logic                fault_ev_to;
    logic [31:0]         fault_ev_addr;
    logic                fault_ev_write;

    // Selected slave as a one-hot vector plus its read-data slice. An index
    // at or above N_SLAVES never reaches ACCESS, so it simply decodes to zero.
    always_comb begin
        sel_oh      = '0;
        slave_rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_q == 4'(i)) begin
                sel_oh[i]   = 1'b1;
                slave_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign map_sel  = MAP[{m_addr[31:28], 2'b00} +: 4];
    assign unmapped = (map_sel == 4'hF) || ({28'd0, map_sel} >= 32'(N_SLAVES));

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        sel_d          = sel_q;
        cnt_d          = cnt_q;
        // Response registers only hold a value during RESP.
        rdata_d        = '0;
        err_d          = 1'b0;
        fault_event    = 1'b0;
        fault_ev_to    = 1'b0;
        fault_ev_addr  = addr_q;
        fault_ev_write = |wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (m_valid) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    sel_d   = map_sel;
                    cnt_d   = '0;
                    if (unmapped) begin
                        state_d        = S_RESP;
                        err_d          = 1'b1;
                        fault_event    = 1'b1;
                        fault_ev_addr  = m_addr;
                        fault_ev_write = |m_wstrb;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // A ready on the last allowed cycle still wins over the timeout.
                if (|(s_ready & sel_oh)) begin
                    rdata_d = slave_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d       = 1'b1;
                    fault_event = 1'b1;
                    fault_ev_to = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A clear arriving together with a new fault re-arms the log and lets the
    // new fault in, so fault_valid stays high across that cycle.
    always_comb begin
        fault_valid_d   = fault_valid_q & ~fault_clear;
        fault_addr_d    = fault_addr_q;
        fault_write_d   = fault_write_q;
        fault_timeout_d = fault_timeout_q;
        if (fault_event && (!fault_valid_q || fault_clear)) begin
            fault_valid_d   = 1'b1;
            fault_addr_d    = fault_ev_addr;
            fault_write_d   = fault_ev_write;
            fault_timeout_d = fault_ev_to;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            sel_q           <= '0;
            cnt_q           <= '0;
            rdata_q         <= '0;
            err_q           <= 1'b0;
            fault_valid_q   <= 1'b0;
            fault_addr_q    <= '0;
            fault_write_q   <= 1'b0;
            fault_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            sel_q           <= sel_d;
            cnt_q           <= cnt_d;
            rdata_q         <= rdata_d;
            err_q           <= err_d;
            fault_valid_q   <= fault_valid_d;
            fault_addr_q    <= fault_addr_d;
            fault_write_q   <= fault_write_d;
            fault_timeout_q <= fault_timeout_d;
        end
    end

    assign m_ready       = (state_q == S_RESP);
    assign m_rdata       = rdata_q;
    assign m_err         = err_q;
    assign s_valid       = (state_q == S_ACCESS) ? sel_oh : '0;
    assign s_addr        = addr_q;
    assign s_wdata       = wdata_q;
    assign s_wstrb       = (state_q == S_ACCESS) ? wstrb_q : 4'b0000;
    assign fault_valid   = fault_valid_q;
    assign fault_addr    = fault_addr_q;
    assign fault_write   = fault_write_q;
    assign fault_timeout = fault_timeout_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// tb_mmio_fabric
//   Directed bench for mmio_fabric. The stimulus task pushes the expected
//   {m_err, m_rdata} for each request into a queue and plays the slave side;
//   an independent monitor pops and compares whenever m_ready is seen.
//   Map used here: nibble 0..2 -> slaves 0..2, nibble 3 -> 9 (out of range),
//   nibble 4..9 -> slaves 3..8, nibble 10..15 -> unmapped. TIMEOUT = 4.

module tb_mmio_fabric;

    localparam int          N     = 9;
    localparam logic [63:0] MAP_T = 64'hFFFF_FF87_6543_9210;
    localparam int          TO    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m_valid = 1'b0;
    logic [31:0]      m_addr = '0;
    logic [31:0]      m_wdata = '0;
    logic [3:0]       m_wstrb = '0;
    logic             m_ready;
    logic [31:0]      m_rdata;
    logic             m_err;
    logic [N-1:0]     s_valid;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [N-1:0]     s_ready = '0;
    logic [32*N-1:0]  s_rdata = '0;
    logic             fault_valid;
    logic [31:0]      fault_addr;
    logic             fault_write;
    logic             fault_timeout;
    logic             fault_clear = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] sb[$];

    mmio_fabric #(
        .N_SLAVES(N),
        .MAP     (MAP_T),
        .TIMEOUT (TO),
        .TO_W    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_valid      (m_valid),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_ready      (m_ready),
        .m_rdata      (m_rdata),
        .m_err        (m_err),
        .s_valid      (s_valid),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_ready      (s_ready),
        .s_rdata      (s_rdata),
        .fault_valid  (fault_valid),
        .fault_addr   (fault_addr),
        .fault_write  (fault_write),
        .fault_timeout(fault_timeout),
        .fault_clear  (fault_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every m_ready; outside RESP the
    // registered response must read as zero.
    always @(negedge clk) begin
        if (m_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_m_ready: got m_ready=1 expected no response (t=%0t)", $time);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("m_err", {63'd0, m_err}, {63'd0, e[32]});
                chk("m_rdata", {32'd0, m_rdata}, {32'd0, e[31:0]});
            end
        end else begin
            chk("idle_resp_zero", {31'd0, m_err, m_rdata}, 64'd0);
        end
    end

    // slv < 0: no slave should be selected. wait_n < 0: slave never answers.
    task automatic run(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int slv, input int wait_n,
                       input logic [31:0] rdata, input logic exp_err,
                       input int exp_sv, input int exp_lat, input logic clr);
        logic [N-1:0] exp_oh;
        int cyc;
        int sv_cnt;
        int lat;
        bit got;
        exp_oh = '0;
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = 32'h5A00_0000 | i;
        if (slv >= 0) begin
            exp_oh[slv] = 1'b1;
            s_rdata[32*slv +: 32] = rdata;
        end
        sb.push_back({exp_err, exp_err ? 32'd0 : rdata});
        @(negedge clk);
        m_valid = 1'b1;
        m_addr = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        fault_clear = clr;
        cyc = 0;
        sv_cnt = 0;
        lat = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            fault_clear = 1'b0;
            if (s_valid != '0) begin
                chk("s_valid", {55'd0, s_valid}, {55'd0, exp_oh});
                chk("s_addr", {32'd0, s_addr}, {32'd0, addr});
                chk("s_wdata", {32'd0, s_wdata}, {32'd0, wdata});
                chk("s_wstrb", {60'd0, s_wstrb}, {60'd0, wstrb});
                // unselected slaves shout ready all the time; only ours matters
                s_ready = (sv_cnt == wait_n) ? '1 : ~exp_oh;
                sv_cnt++;
            end else begin
                chk("s_wstrb_idle", {60'd0, s_wstrb}, 64'd0);
                s_ready = '0;
            end
            if (m_ready) begin
                got = 1;
                lat = cyc;
                m_valid = 1'b0;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_no_m_ready: got no m_ready in %0d cycles expected one at %0d", cyc, exp_lat);
            m_valid = 1'b0;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("s_valid_cycles", 64'(sv_cnt), 64'(exp_sv));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fault(input string name, input logic v, input logic [31:0] a,
                             input logic w, input logic t);
        chk(name, {29'd0, fault_valid, fault_write, fault_timeout, fault_addr},
                  {29'd0, v, w, t, a});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {30'd0, m_ready, m_err, m_rdata}, 64'd0);
        chk("reset_slave", {24'd0, s_valid, s_wstrb, fault_valid, fault_write, fault_timeout, 20'd0}, 64'd0);
        chk_fault("reset_fault", 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // zero-wait read of slave 1
        run(32'h1000_0004, 32'h0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1, 2, 1'b0);
        // write to slave 0 with three wait cycles
        run(32'h0000_0010, 32'h1234_5678, 4'b0011, 0, 3, 32'hCAFE_0000, 1'b0, 4, 5, 1'b0);
        // highest slave index, one wait cycle
        run(32'h9000_00FC, 32'hA5A5_5A5A, 4'b1000, 8, 1, 32'h1234_ABCD, 1'b0, 2, 3, 1'b0);
        chk_fault("no_fault_yet", 1'b0, 32'd0, 1'b0, 1'b0);

        // unmapped nibble 12
        run(32'hC000_0000, 32'h0, 4'b0000, -1, -1, 32'h0, 1'b1, 0, 1, 1'b0);
        chk_fault("unmapped_logged", 1'b1, 32'hC000_0000, 1'b0, 1'b0);
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        chk_fault("fault_cleared", 1'b0, 32'hC000_0000, 1'b0, 1'b0);

        // slave 2 never ready: timeout after 4 access cycles
        run(32'h2000_0008, 32'h0BAD_0BAD, 4'b1111, 2, -1, 32'h0, 1'b1, 4, 5, 1'b0);
        chk_fault("timeout_logged", 1'b1, 32'h2000_0008, 1'b1, 1'b1);
        // index 9 >= N_SLAVES is unmapped; log keeps the first fault
        run(32'h3000_0000, 32'h0, 4'b0000, -1, -1, 32'h0, 1'b1, 0, 1, 1'b0);
        chk_fault("first_fault_kept", 1'b1, 32'h2000_0008, 1'b1, 1'b1);

        // clear in the same cycle as a new unmapped fault
        run(32'hA000_0000, 32'h0, 4'b0000, -1, -1, 32'h0, 1'b1, 0, 1, 1'b1);
        chk_fault("clear_with_fault", 1'b1, 32'hA000_0000, 1'b0, 1'b0);

        // reset in the middle of an access to slave 5
        @(negedge clk);
        m_valid = 1'b1;
        m_addr = 32'h6000_0040;
        m_wdata = 32'h7777_7777;
        m_wstrb = 4'b0101;
        @(posedge clk);
        #1;
        chk("rst_pre_s_valid", {55'd0, s_valid}, 64'h20);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        #1;
        chk("rst_mid_master", {30'd0, m_ready, m_err, m_rdata}, 64'd0);
        chk("rst_mid_slave", {19'd0, s_valid, s_wstrb, s_addr}, 64'd0);
        chk_fault("rst_mid_fault", 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_no_late_resp", 64'(sb.size()), 64'd0);

        run(32'h4000_0000, 32'h0, 4'b0000, 3, 1, 32'h0BAD_F00D, 1'b0, 2, 3, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
